rgb_channel_ctrl: RTL and testbench

Controller that shares one quadrature rotary encoder and one push button between the three colour channels of the RGB mixer. It synchronizes and decodes the encoder pins, debounces the button, keeps a channel-select state machine and owns the three 8-bit channel registers that feed the PWM stage. A short press selects the next channel. A long press clears the selected channel.

---
 rtl/rgb_channel_ctrl.sv | 125 ++++++++++++
 tb/tb_rgb_channel_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_channel_ctrl.sv
// Shared encoder/button front end for the RGB mixer: sync, quadrature decode,
// button debounce, channel-select FSM and the three channel registers.
module rgb_channel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter bit SATURATE        = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       btn,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [2:0] sel,
  output logic       changed,
  output logic       glitch
);
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = $clog2(LONG_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HELD = 2'd1;
  localparam logic [1:0] S_LONG = 2'd2;

  logic [1:0]    a_s, b_s, btn_s;
  logic          pa, pb;
  logic          db;
  logic [DW-1:0] dcnt;
  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  logic [7:0]    ch     [3];
  logic [7:0]    ch_nxt [3];

  logic a_edge, b_edge, ab_diff, inc, dec, clr, adv, chg;

  assign red   = ch[0];
  assign green = ch[1];
  assign blue  = ch[2];

  // Full Gray decode: each legal single-pin transition is one step, so a
  // complete quadrature cycle yields four steps in one direction.
  always_comb begin
    a_edge  = a_s[1] ^ pa;
    b_edge  = b_s[1] ^ pb;
    ab_diff = a_s[1] ^ b_s[1];
    inc     = (a_edge & ~b_edge & ab_diff) | (b_edge & ~a_edge & ~ab_diff);
    dec     = (b_edge & ~a_edge & ab_diff) | (a_edge & ~b_edge & ~ab_diff);
    // Hold counter starts one cycle after the debounced rise.
    clr     = (state == S_HELD) && db && (hcnt == HW'(LONG_CYCLES - 2));
    adv     = (state == S_HELD) && !db;
  end

  // Clear and step both target the current sel; the clear takes priority.
  always_comb begin
    chg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ch_nxt[i] = ch[i];
      if (sel[i]) begin
        if (clr)
          ch_nxt[i] = 8'd0;
        else if (inc)
          ch_nxt[i] = (SATURATE && ch[i] == 8'hff) ? ch[i] : ch[i] + 8'd1;
        else if (dec)
          ch_nxt[i] = (SATURATE && ch[i] == 8'h00) ? ch[i] : ch[i] - 8'd1;
      end
      chg = chg | (ch_nxt[i] != ch[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_s     <= '0;
      b_s     <= '0;
      btn_s   <= '0;
      pa      <= 1'b0;
      pb      <= 1'b0;
      db      <= 1'b0;
      dcnt    <= '0;
      state   <= S_IDLE;
      hcnt    <= '0;
      sel     <= 3'b001;
      changed <= 1'b0;
      glitch  <= 1'b0;
      for (int i = 0; i < 3; i++) ch[i] <= 8'd0;
    end else begin
      a_s     <= {a_s[0], a};
      b_s     <= {b_s[0], b};
      btn_s   <= {btn_s[0], btn};
      pa      <= a_s[1];
      pb      <= b_s[1];
      changed <= chg;
      glitch  <= a_edge & b_edge;
      for (int i = 0; i < 3; i++) ch[i] <= ch_nxt[i];

      if (btn_s[1] != db) begin
        if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          db   <= btn_s[1];
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end else begin
        dcnt <= '0;
      end

      if (adv) sel <= {sel[1:0], sel[2]};

      case (state)
        S_IDLE: if (db) begin
          state <= S_HELD;
          hcnt  <= '0;
        end
        S_HELD: begin
          if (!db)      state <= S_IDLE;
          else if (clr) state <= S_LONG;
          else          hcnt  <= hcnt + HW'(1);
        end
        S_LONG: if (!db) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgb_channel_ctrl.sv
// Scoreboard bench: a saturating and a wrapping instance share all inputs.
module tb_rgb_channel_ctrl;
  logic clk = 1'b0, reset = 1'b0, a = 1'b0, b = 1'b0, btn = 1'b0;
  logic [7:0] red_s, green_s, blue_s, red_w, green_w, blue_w;
  logic [2:0] sel_s, sel_w;
  logic chg_s, chg_w, gl_s, gl_w;

  always #5 clk = ~clk;

  rgb_channel_ctrl #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(50), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .a(a), .b(b), .btn(btn),
    .red(red_s), .green(green_s), .blue(blue_s), .sel(sel_s),
    .changed(chg_s), .glitch(gl_s));

  rgb_channel_ctrl #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(50), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .a(a), .b(b), .btn(btn),
    .red(red_w), .green(green_w), .blue(blue_w), .sel(sel_w),
    .changed(chg_w), .glitch(gl_w));

  typedef struct packed {
    logic [7:0] r, g, bl;
    logic [2:0] s;
    logic       c;
  } exp_t;

  exp_t sq[$], wq[$];
  logic [7:0] ms[3], mw[3];
  logic [2:0] msel;
  logic [1:0] ab;
  int total = 0, bad = 0, chg_cnt = 0;

  always @(negedge clk) if (chg_s === 1'b1) chg_cnt++;

  function automatic int sidx(input logic [2:0] s);
    return s[0] ? 0 : (s[1] ? 1 : 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin ms[i] = 8'd0; mw[i] = 8'd0; end
    msel = 3'b001;
    ab   = 2'b00;
  endtask

  // One legal Gray transition; expectation queued now, popped at edge N+2.
  task automatic enc_step(input bit cw);
    logic [1:0] nx;
    exp_t e;
    bit cs;
    int i;
    if (cw) case (ab) 2'b00: nx = 2'b10; 2'b10: nx = 2'b11; 2'b11: nx = 2'b01; default: nx = 2'b00; endcase
    else    case (ab) 2'b00: nx = 2'b01; 2'b01: nx = 2'b11; 2'b11: nx = 2'b10; default: nx = 2'b00; endcase
    i  = sidx(msel);
    cs = 1'b0;
    if (cw) begin
      if (ms[i] != 8'hff) begin ms[i] = ms[i] + 8'd1; cs = 1'b1; end
      mw[i] = mw[i] + 8'd1;
    end else begin
      if (ms[i] != 8'h00) begin ms[i] = ms[i] - 8'd1; cs = 1'b1; end
      mw[i] = mw[i] - 8'd1;
    end
    sq.push_back({ms[0], ms[1], ms[2], msel, cs});
    wq.push_back({mw[0], mw[1], mw[2], msel, 1'b1});
    ab = nx; a = nx[1]; b = nx[0];
    repeat (3) @(negedge clk);
    e = sq.pop_front();
    total++;
    if ({red_s, green_s, blue_s, sel_s, chg_s} !== e) begin
      bad++;
      $display("FAIL step_sat got=%h exp=%h", {red_s, green_s, blue_s, sel_s, chg_s}, e);
    end
    e = wq.pop_front();
    total++;
    if ({red_w, green_w, blue_w, sel_w, chg_w} !== e) begin
      bad++;
      $display("FAIL step_wrap got=%h exp=%h", {red_w, green_w, blue_w, sel_w, chg_w}, e);
    end
    @(negedge clk);
    total++;
    if ({chg_s, chg_w} !== 2'b00) begin
      bad++;
      $display("FAIL step_pulse_width got=%b exp=00", {chg_s, chg_w});
    end
  endtask

  task automatic test_reset();
    a = 1'b1; b = 1'b1; btn = 1'b1; reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({red_s, green_s, blue_s, sel_s, chg_s, red_w, green_w, blue_w, sel_w, chg_w} !== {24'd0, 3'b001, 1'b0, 24'd0, 3'b001, 1'b0}) begin
      bad++;
      $display("FAIL reset_vals got=%h/%h/%h sel=%b chg=%b", red_s, green_s, blue_s, sel_s, chg_s);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({red_s, green_s, blue_s, sel_s, chg_s, red_w, green_w, blue_w, sel_w, chg_w} !== {24'd0, 3'b001, 1'b0, 24'd0, 3'b001, 1'b0}) begin
      bad++;
      $display("FAIL reset_static got=%h/%h/%h sel=%b chg=%b", red_s, green_s, blue_s, sel_s, chg_s);
    end
    reset = 1'b0; a = 1'b0; b = 1'b0; btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_increment();
    int n0;
    n0 = chg_cnt;
    for (int k = 0; k < 8; k++) enc_step(1'b1);
    total++;
    if (red_s !== 8'd8 || (chg_cnt - n0) != 8) begin
      bad++;
      $display("FAIL inc8 got red=%0d pulses=%0d exp red=8 pulses=8", red_s, chg_cnt - n0);
    end
    for (int k = 0; k < 3; k++) enc_step(1'b0);
    total++;
    if (red_s !== 8'd5) begin
      bad++;
      $display("FAIL dec3 got red=%0d exp=5", red_s);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 5; k++) enc_step(1'b0);
    enc_step(1'b0);
    total++;
    if (red_s !== 8'd0 || red_w !== 8'd255) begin
      bad++;
      $display("FAIL underflow got sat=%0d wrap=%0d exp sat=0 wrap=255", red_s, red_w);
    end
    enc_step(1'b1);
    total++;
    if (red_s !== 8'd1 || red_w !== 8'd0) begin
      bad++;
      $display("FAIL overflow got sat=%0d wrap=%0d exp sat=1 wrap=0", red_s, red_w);
    end
  endtask

  task automatic test_short_press();
    for (int k = 0; k < 3; k++) begin
      btn = 1'b1; repeat (2) @(negedge clk);
      btn = 1'b0; repeat (2) @(negedge clk);
    end
    btn = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if ({sel_s, sel_w} !== {3'b001, 3'b001}) begin
      bad++;
      $display("FAIL press_held got sel=%b exp=001", sel_s);
    end
    btn = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (sel_s !== 3'b001) begin
      bad++;
      $display("FAIL release_early got sel=%b exp=001", sel_s);
    end
    @(negedge clk);
    msel = 3'b010;
    total++;
    if ({sel_s, sel_w} !== {msel, msel}) begin
      bad++;
      $display("FAIL advance got sel=%b exp=%b", sel_s, msel);
    end
    repeat (10) @(negedge clk);
    total++;
    if (sel_s !== msel || red_s !== ms[0] || red_w !== mw[0]) begin
      bad++;
      $display("FAIL advance_once got sel=%b red=%0d exp sel=%b red=%0d", sel_s, red_s, msel, ms[0]);
    end
    enc_step(1'b1);
    total++;
    if (green_s !== 8'd1 || green_w !== 8'd1) begin
      bad++;
      $display("FAIL green_step got=%0d exp=1", green_s);
    end
  endtask

  task automatic test_long_press();
    exp_t e;
    int n0;
    btn = 1'b1; repeat (10) @(negedge clk);
    btn = 1'b0; repeat (10) @(negedge clk);
    msel = 3'b100;
    total++;
    if (sel_s !== msel) begin
      bad++;
      $display("FAIL sel_blue got=%b exp=100", sel_s);
    end
    for (int k = 0; k < 40; k++) enc_step(1'b1);
    btn = 1'b1;
    n0  = chg_cnt;
    ms[2] = 8'd0; mw[2] = 8'd0;
    sq.push_back({ms[0], ms[1], ms[2], msel, 1'b1});
    repeat (55) @(negedge clk);
    total++;
    if (blue_s !== 8'd40 || blue_w !== 8'd40) begin
      bad++;
      $display("FAIL pre_clear got blue=%0d exp=40", blue_s);
    end
    @(negedge clk);
    e = sq.pop_front();
    total++;
    if ({red_s, green_s, blue_s, sel_s, chg_s} !== e || blue_w !== 8'd0) begin
      bad++;
      $display("FAIL long_clear got=%h exp=%h", {red_s, green_s, blue_s, sel_s, chg_s}, e);
    end
    @(negedge clk);
    total++;
    if (chg_s !== 1'b0) begin
      bad++;
      $display("FAIL clear_pulse got=%b exp=0", chg_s);
    end
    repeat (44) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (sel_s !== 3'b100 || blue_s !== 8'd0 || (chg_cnt - n0) != 1) begin
      bad++;
      $display("FAIL long_release got sel=%b blue=%0d pulses=%0d exp 100/0/1", sel_s, blue_s, chg_cnt - n0);
    end
  endtask

  task automatic test_glitch();
    ab = ~ab; a = ab[1]; b = ab[0];
    repeat (3) @(negedge clk);
    total++;
    if ({gl_s, gl_w, chg_s} !== 3'b110 || {red_s, green_s, blue_s} !== {ms[0], ms[1], ms[2]}) begin
      bad++;
      $display("FAIL glitch got gl=%b chg=%b rgb=%h exp gl=1 chg=0 rgb=%h", gl_s, chg_s, {red_s, green_s, blue_s}, {ms[0], ms[1], ms[2]});
    end
    @(negedge clk);
    total++;
    if ({gl_s, gl_w} !== 2'b00) begin
      bad++;
      $display("FAIL glitch_width got=%b exp=00", {gl_s, gl_w});
    end
  endtask

  task automatic test_mid_reset();
    btn = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b0; a = 1'b0; b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    btn = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if ({sel_s, sel_w} !== {3'b001, 3'b001} || {red_s, green_s, blue_s} !== 24'd0) begin
      bad++;
      $display("FAIL mid_reset got sel=%b rgb=%h exp sel=001 rgb=0", sel_s, {red_s, green_s, blue_s});
    end
    enc_step(1'b1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_increment();
    test_saturate();
    test_short_press();
    test_long_press();
    test_glitch();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
